pc_seg_display: RTL
===================

# pc_seg_display

Display-side companion to the button debouncer / PC stepper: consumes the 8-bit program counter and the jump-taken flag and drives a 4-digit multiplexed common-anode seven-segment display. Digits 1:0 show the PC in hex; digits 3:2 show a wrapping count of PC updates. A decimal point marks whether the last update was a taken jump. Sits between the PC register and the board display pins.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (≈1 kHz per digit at 50 MHz); must be ≥ BLANK_CYC+2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_LEN, 25000000: cycles the update-indicator DP stays lit (used only with the blink feature).
- i_clk  in  1  system clock.
- i_reset  in  1  reset i_reset, synchronous, active-low; clock i_clk.
- i_pc  in  8  current program counter, from the PC stepper.
- i_jump_taken  in  1  high when the stepper's current update came from the jump address.
- o_an  out  4  digit anodes, active-low; bit n = digit n (digit 0 rightmost).
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- o_dp  out  1  decimal point, active-low.

## Operation
- Change detect: pc_q registers i_pc every cycle; update = (i_pc != pc_q). On update: step_cnt <= step_cnt+1 (8-bit, 255 wraps to 0); jump_q <= i_jump_taken. No update → both hold.
- Scan: div counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0.
- Snapshot: on each div wrap, nibble for the next idx is latched (idx0 = pc_q[3:0], 1 = pc_q[7:4], 2 = step_cnt[3:0], 3 = step_cnt[7:4]); no mid-slot tearing.
- Glyphs: hex 0–F, lowercase b and d, uppercase A, C, E, F.
- Anodes: div < BLANK_CYC → o_an = 4'hF; otherwise only bit idx low.
- DP: lit on digit 1 while jump_q = 1; see Configuration for digit 0.
- Simultaneous update and div wrap: snapshot takes pre-update values; new values appear on the next visit to that digit.
- All outputs registered.

## Timing
- Reset (i_reset low at a clock edge): pc_q <= i_pc (no spurious update), step_cnt 0, jump_q 0, div 0, idx 0, blink counter 0, o_an 4'hF, o_seg 7'h7F, o_dp 1.
- Reset mid-slot: scan restarts at idx 0 and div 0, and blanking applies at once.
- Update latency: i_pc change at edge N → step_cnt incremented at edge N+1.
- Output latency: o_an/o_seg/o_dp change one cycle after the div/idx state that selects them. Anode and segment change on the same edge.
- Full frame = 4·REFRESH_DIV cycles.

## Configuration
- PC_DISP_BLINK_EN defined: each update loads a blink counter with BLINK_LEN. While the counter is nonzero, the DP on digit 0 is lit. A new update during the count reloads it to BLINK_LEN. The counter decrements to 0 and stops.
- Not defined: no blink counter; digit-0 DP is never lit. All other behaviour is identical.

## Structure
- Package pc_disp_pkg holds:
  - NUM_DIGITS = 4;
  - the 16-entry active-low hex glyph constant array;
  - SEG_BLANK = 7'h7F;
  - the digit-index typedef (2-bit).
- Sub-module hex_to_seg7: combinational 4-bit nibble → 7-bit active-low glyph, indexed from the package table. Used once on the snapshot nibble.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYC=2, BLINK_LEN=20.
- Reset held 3 cycles with i_pc=8'h5A → o_an=4'hF, o_seg=7'h7F, o_dp=1. After release, step_cnt stays 0 and digits 1:0 show "5A" (seg 7'h12, 7'h08).
- i_pc held 8'h3C, run 4 slots → anodes cycle 4'hE, 4'hD, 4'hB, 4'h7. Each slot has 2 cycles of 4'hF, then 6 cycles active. Digits show C, 3, 0, 0.
- Apply 257 distinct i_pc changes → step_cnt wraps, and digits 3:2 show "01".
- Change i_pc with i_jump_taken=1 → digit 1 DP lit on later scans. Next change with i_jump_taken=0 → digit 1 DP off.
- With PC_DISP_BLINK_EN, a change at cycle T → digit-0 DP lit through T+20. A second change at T+10 extends it to T+30. Without the macro, digit-0 DP stays 1.
- Reset asserted mid-slot at idx 2 → next cycle o_an=4'hF, and the scan resumes at idx 0.

Source files
------------

// File: rtl/pc_disp_pkg.sv
// Shared constants and helpers for the PC seven-segment display.
// Glyphs are active-low {g,f,e,d,c,b,a}; A, C, E, F uppercase, b and d lowercase.
package pc_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Digits 1:0 carry the PC and digits 3:2 carry the update count.
  function automatic logic [3:0] nibble_sel(input digit_idx_t idx,
                                            input logic [7:0] pc,
                                            input logic [7:0] cnt);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = pc[3:0];
      2'd1:    nib = pc[7:4];
      2'd2:    nib = cnt[3:0];
      default: nib = cnt[7:4];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
  import pc_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[nib_i];

endmodule

// File: rtl/pc_seg_display.sv
// Multiplexed 4-digit display of the PC (digits 1:0) and update count (digits 3:2).
// Define PC_DISP_BLINK_EN to light the digit-0 DP for BLINK_LEN cycles after each update.
module pc_seg_display
  import pc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int BLINK_LEN   = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_pc,
  input  logic                  i_jump_taken,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [6:0]            o_seg,
  output logic                  o_dp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  logic [7:0]            pc_q;
  logic [7:0]            step_q, step_d;
  logic                  jump_q, jump_d;
  logic [DIV_W-1:0]      div_q, div_d;
  digit_idx_t            idx_q, idx_d;
  logic [3:0]            nib_q, nib_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  update, wrap, blanking, blink_on;
  logic [6:0]            glyph;

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (nib_q),
    .seg_o (glyph)
  );

`ifdef PC_DISP_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_LEN + 1);
  logic [BLINK_W-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (update)            blink_d = BLINK_W'(BLINK_LEN);
    else if (blink_q != 0) blink_d = blink_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) blink_q <= '0;
    else          blink_q <= blink_d;
  end

  assign blink_on = (blink_q != '0);
`else
  assign blink_on = 1'b0;
`endif

  always_comb begin
    update   = (i_pc != pc_q);
    wrap     = (div_q == DIV_LAST);
    blanking = (div_q < BLANK_END);
    step_d   = update ? step_q + 8'd1 : step_q;
    jump_d   = update ? i_jump_taken : jump_q;
    div_d    = wrap ? '0 : div_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    // Snapshot uses register values, so an update on the wrap edge shows next visit.
    nib_d    = wrap ? nibble_sel(idx_q + 2'd1, pc_q, step_q) : nib_q;
    an_d     = '1;
    seg_d    = SEG_BLANK;
    dp_d     = 1'b1;
    if (!blanking) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      dp_d        = !(((idx_q == 2'd1) && jump_q) || ((idx_q == 2'd0) && blink_on));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_q   <= i_pc;
      step_q <= '0;
      jump_q <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      nib_q  <= i_pc[3:0];
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      pc_q   <= i_pc;
      step_q <= step_d;
      jump_q <= jump_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      nib_q  <= nib_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule
